// File: rtl/dmem_pkg.sv
// Shared types and constants for the dmem_resp data-memory responder.
// Holds the FSM state encoding, CPU word width and LFSR seed.
package dmem_pkg;

    localparam int unsigned CPU_W     = 32;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Byte lanes touched by an access; anything in [7:4] spills past the word.
    function automatic logic [7:0] lane_span(input logic [3:0] mask, input logic [1:0] off);
        return {4'b0000, mask} << off;
    endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response bus between a CPU-side master and the dmem_resp slave.
// Signal names keep the i_/o_ direction prefixes as seen from the memory.
interface dmem_if;
    import dmem_pkg::*;

    logic             i_req_valid;
    logic             o_req_ready;
    logic             i_req_wen;
    logic [CPU_W-1:0] i_req_addr;
    logic [CPU_W-1:0] i_req_wdata;
    logic [7:0]       i_req_wmask;
    logic             o_rsp_valid;
    logic             i_rsp_ready;
    logic [CPU_W-1:0] o_rsp_rdata;
    logic             o_rsp_err;

    modport slave (
        input  i_req_valid, i_req_wen, i_req_addr, i_req_wdata, i_req_wmask, i_rsp_ready,
        output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err
    );

    modport master (
        output i_req_valid, i_req_wen, i_req_addr, i_req_wdata, i_req_wmask, i_rsp_ready,
        input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err
    );

endinterface

// File: rtl/dmem_lfsr.sv
// 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1) advancing once per enable.
// Only instantiated when DMEM_RAND_DELAY_EN is defined.
module dmem_lfsr
    import dmem_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    output logic [15:0] state_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (en_i) begin
            lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign state_o = lfsr_q;

endmodule

// File: rtl/dmem_resp.sv
// Single-outstanding data memory with fixed response latency and byte-lane stores.
// Define DMEM_RAND_DELAY_EN to add 0..3 LFSR-chosen wait cycles per request.
module dmem_resp
    import dmem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic    i_clk,
    input  logic    i_rst,
    dmem_if.slave   bus
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W = 5;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wen_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic [3:0]       wmask_q;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;

    logic [31:0]      mem_q [DEPTH_WORDS];

    logic             accept;
    logic             commit;
    logic             wr_en;
    logic             acc_err;
    logic [31:0]      diff;
    logic [29:0]      index;
    logic [IDX_W-1:0] idx;
    logic [1:0]       offset;
    logic [7:0]       span;
    logic [4:0]       shamt;
    logic [31:0]      wdata_sh;
    logic [CNT_W-1:0] extra;
    logic             unused_bits;

`ifdef DMEM_RAND_DELAY_EN
    logic [15:0] lfsr_state;
    logic        unused_lfsr;

    dmem_lfsr u_lfsr (
        .clk_i   (i_clk),
        .rst_i   (i_rst),
        .en_i    (accept),
        .state_o (lfsr_state)
    );

    // Extra delay uses the LFSR value present at accept, before it steps.
    assign extra       = CNT_W'(lfsr_state[1:0]);
    assign unused_lfsr = ^lfsr_state[15:2];
`else
    assign extra = '0;
`endif

    assign accept = (state_q == IDLE) && bus.i_req_valid;
    assign commit = (state_q == WAIT) && (cnt_q == '0);

    assign offset   = addr_q[1:0];
    assign diff     = addr_q - BASE_ADDR;
    assign index    = diff[31:2];
    assign idx      = index[IDX_W-1:0];
    assign span     = lane_span(wmask_q, offset);
    assign shamt    = {offset, 3'b000};
    assign wdata_sh = wdata_q << shamt;

    assign acc_err = (addr_q < BASE_ADDR)
                  || ({2'b00, index} >= 32'(DEPTH_WORDS))
                  || (span[7:4] != 4'b0000);

    assign wr_en = commit && wen_q && !acc_err;

    assign unused_bits = ^{bus.i_req_wmask[7:4], diff[1:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = WAIT;
                    cnt_d   = CNT_INIT + extra;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    err_d   = acc_err;
                    rdata_d = (!acc_err && !wen_q) ? (mem_q[idx] >> shamt) : '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (bus.i_rsp_ready) begin
                    state_d = IDLE;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else if (accept) begin
            wen_q   <= bus.i_req_wen;
            addr_q  <= bus.i_req_addr;
            wdata_q <= bus.i_req_wdata;
            wmask_q <= bus.i_req_wmask[3:0];
        end
    end

    // Storage is deliberately left out of reset so contents survive i_rst.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            for (int k = 0; k < 4; k++) begin
                if (span[k]) begin
                    mem_q[idx][8*k +: 8] <= wdata_sh[8*k +: 8];
                end
            end
        end
    end

    assign bus.o_req_ready = (state_q == IDLE);
    assign bus.o_rsp_valid = (state_q == RESP);
    assign bus.o_rsp_rdata = rdata_q;
    assign bus.o_rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_resp.sv
// Directed self-checking bench for dmem_resp (BASE 0x8000_0000, 1024 words, LATENCY 2).
// Build with DMEM_RAND_DELAY_EN to also exercise the randomized wait cycles.
module tb_dmem_resp;
    import dmem_pkg::*;

`ifdef DMEM_RAND_DELAY_EN
    localparam int LAT_MAX = 5;
`else
    localparam int LAT_MAX = 2;
`endif
    localparam int LAT_MIN = 2;
    localparam int TMO     = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_if bus ();

    dmem_resp #(
        .BASE_ADDR   (32'h8000_0000),
        .DEPTH_WORDS (1024),
        .LATENCY     (2)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    task automatic drive_req(input logic wen, input logic [31:0] a, input logic [31:0] wd,
                             input logic [7:0] wm);
        bus.i_req_valid = 1'b1;
        bus.i_req_wen   = wen;
        bus.i_req_addr  = a;
        bus.i_req_wdata = wd;
        bus.i_req_wmask = wm;
    endtask

    task automatic wait_accept(output int acc);
        int n = 0;
        while (!bus.o_req_ready && n < TMO) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        acc = cyc;
        bus.i_req_valid = 1'b0;
        if (n >= TMO) begin
            checks++; errors++;
            $display("FAIL accept_timeout waited %0d cycles limit %0d", n, TMO);
        end
    endtask

    task automatic wait_rsp(input int acc, output logic [31:0] rd, output logic er, output int lat);
        int n = 0;
        while (!bus.o_rsp_valid && n < TMO) begin
            @(posedge clk); #1; n++;
        end
        if (n >= TMO) begin
            checks++; errors++;
            $display("FAIL rsp_timeout waited %0d cycles limit %0d", n, TMO);
        end
        lat = cyc - acc;
        rd  = bus.o_rsp_rdata;
        er  = bus.o_rsp_err;
    endtask

    task automatic handshake();
        bus.i_rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.i_rsp_ready = 1'b0;
    endtask

    task automatic xact(input logic wen, input logic [31:0] a, input logic [31:0] wd,
                        input logic [7:0] wm, output logic [31:0] rd, output logic er,
                        output int lat);
        int acc;
        drive_req(wen, a, wd, wm);
        wait_accept(acc);
        wait_rsp(acc, rd, er, lat);
        handshake();
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.o_rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", bus.o_rsp_valid); end
        checks++; if (bus.o_rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", bus.o_rsp_rdata); end
        checks++; if (bus.o_rsp_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", bus.o_rsp_err); end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (bus.o_req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", bus.o_req_ready); end
    endtask

    task automatic test_store_load();
        logic [31:0] rd; logic er; int lat;
        xact(1'b1, 32'h8000_0000, 32'hDEAD_BEEF, 8'h0F, rd, er, lat);
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL st_err got %b exp 0", er); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL st_rdata got %h exp 0", rd); end
        checks++; if (lat < LAT_MIN || lat > LAT_MAX) begin errors++; $display("FAIL st_latency got %0d exp %0d..%0d", lat, LAT_MIN, LAT_MAX); end
        xact(1'b0, 32'h8000_0000, 32'h0, 8'h0F, rd, er, lat);
        checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ld_rdata got %h exp deadbeef", rd); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL ld_err got %b exp 0", er); end
        checks++; if (lat < LAT_MIN || lat > LAT_MAX) begin errors++; $display("FAIL ld_latency got %0d exp %0d..%0d", lat, LAT_MIN, LAT_MAX); end
    endtask

    task automatic test_byte_store();
        logic [31:0] rd; logic er; int lat;
        xact(1'b1, 32'h8000_0004, 32'h1122_3344, 8'h0F, rd, er, lat);
        xact(1'b1, 32'h8000_0006, 32'h0000_00A5, 8'h01, rd, er, lat);
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL byte_st_err got %b exp 0", er); end
        xact(1'b0, 32'h8000_0004, 32'h0, 8'h0F, rd, er, lat);
        checks++; if (rd !== 32'h11A5_3344) begin errors++; $display("FAIL byte_ld_word got %h exp 11a53344", rd); end
        xact(1'b0, 32'h8000_0006, 32'h0, 8'h03, rd, er, lat);
        checks++; if (rd !== 32'h0000_11A5) begin errors++; $display("FAIL half_ld_off2 got %h exp 000011a5", rd); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL half_ld_err got %b exp 0", er); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat;
        xact(1'b1, 32'h8000_0003, 32'h0000_BEEF, 8'h03, rd, er, lat);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL straddle_err got %b exp 1", er); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL straddle_rdata got %h exp 0", rd); end
        xact(1'b0, 32'h8000_0000, 32'h0, 8'h0F, rd, er, lat);
        checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL straddle_nowrite got %h exp deadbeef", rd); end
        xact(1'b0, 32'h7FFF_FFFC, 32'h0, 8'h0F, rd, er, lat);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL below_base_err got %b exp 1", er); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL below_base_rdata got %h exp 0", rd); end
        xact(1'b0, 32'h8000_1000, 32'h0, 8'h0F, rd, er, lat);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL past_end_err got %b exp 1", er); end
        xact(1'b1, 32'h8000_0FFC, 32'h1234_5678, 8'h0F, rd, er, lat);
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL last_word_st_err got %b exp 0", er); end
        xact(1'b0, 32'h8000_0FFC, 32'h0, 8'h0F, rd, er, lat);
        checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL last_word_ld got %h exp 12345678", rd); end
        xact(1'b0, 32'h8000_0003, 32'h0, 8'h01, rd, er, lat);
        checks++; if (rd !== 32'h0000_00DE || er !== 1'b0) begin errors++; $display("FAIL byte_ld_off3 got %h/%b exp 000000de/0", rd, er); end
        xact(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 8'h00, rd, er, lat);
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL zero_mask_err got %b exp 0", er); end
        xact(1'b0, 32'h8000_0000, 32'h0, 8'h0F, rd, er, lat);
        checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL zero_mask_nowrite got %h exp deadbeef", rd); end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd; logic er; int lat; int acc; int acc2; int hs;
        drive_req(1'b0, 32'h8000_0004, 32'h0, 8'h0F);
        wait_accept(acc);
        wait_rsp(acc, rd, er, lat);
        checks++; if (rd !== 32'h11A5_3344) begin errors++; $display("FAIL bp_rdata got %h exp 11a53344", rd); end
        drive_req(1'b1, 32'h8000_0008, 32'h0000_0055, 8'h0F);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++; if (bus.o_rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid cyc %0d got %b exp 1", i, bus.o_rsp_valid); end
            checks++; if (bus.o_rsp_rdata !== 32'h11A5_3344) begin errors++; $display("FAIL bp_hold_rdata cyc %0d got %h exp 11a53344", i, bus.o_rsp_rdata); end
            checks++; if (bus.o_rsp_err !== 1'b0) begin errors++; $display("FAIL bp_hold_err cyc %0d got %b exp 0", i, bus.o_rsp_err); end
            checks++; if (bus.o_req_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_ready cyc %0d got %b exp 0", i, bus.o_req_ready); end
        end
        bus.i_rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.i_rsp_ready = 1'b0;
        hs = cyc;
        checks++; if (bus.o_req_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after got %b exp 1", bus.o_req_ready); end
        checks++; if (bus.o_rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_after got %b exp 0", bus.o_rsp_valid); end
        wait_accept(acc2);
        checks++; if (acc2 !== hs + 1) begin errors++; $display("FAIL bp_accept_cycle got %0d exp %0d", acc2, hs + 1); end
        wait_rsp(acc2, rd, er, lat);
        handshake();
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL bp_second_err got %b exp 0", er); end
        xact(1'b0, 32'h8000_0008, 32'h0, 8'h0F, rd, er, lat);
        checks++; if (rd !== 32'h0000_0055) begin errors++; $display("FAIL bp_second_data got %h exp 00000055", rd); end
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd; logic er; int lat; int acc;
        xact(1'b1, 32'h8000_0010, 32'h0, 8'h0F, rd, er, lat);
        drive_req(1'b1, 32'h8000_0010, 32'hCAFE_F00D, 8'h0F);
        wait_accept(acc);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++; if (bus.o_rsp_valid !== 1'b0) begin errors++; $display("FAIL abort_valid got %b exp 0", bus.o_rsp_valid); end
        checks++; if (bus.o_rsp_rdata !== 32'h0) begin errors++; $display("FAIL abort_rdata got %h exp 0", bus.o_rsp_rdata); end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (bus.o_req_ready !== 1'b1) begin errors++; $display("FAIL abort_ready got %b exp 1", bus.o_req_ready); end
        xact(1'b0, 32'h8000_0010, 32'h0, 8'h0F, rd, er, lat);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL abort_nowrite got %h exp 0", rd); end
        xact(1'b0, 32'h8000_0000, 32'h0, 8'h0F, rd, er, lat);
        checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mem_survives_rst got %h exp deadbeef", rd); end
    endtask

`ifdef DMEM_RAND_DELAY_EN
    task automatic test_rand_delay();
        logic [31:0] addrs [3];
        logic [31:0] exps  [3];
        logic [31:0] rd; logic er; int lat;
        addrs[0] = 32'h8000_0000; exps[0] = 32'hDEAD_BEEF;
        addrs[1] = 32'h8000_0004; exps[1] = 32'h11A5_3344;
        addrs[2] = 32'h8000_0FFC; exps[2] = 32'h1234_5678;
        for (int i = 0; i < 100; i++) begin
            xact(1'b0, addrs[i % 3], 32'h0, 8'h0F, rd, er, lat);
            checks++; if (lat < 2 || lat > 5) begin errors++; $display("FAIL rand_latency iter %0d got %0d exp 2..5", i, lat); end
            checks++; if (rd !== exps[i % 3]) begin errors++; $display("FAIL rand_data iter %0d got %h exp %h", i, rd, exps[i % 3]); end
        end
    endtask
`endif

    initial begin
        bus.i_req_valid = 1'b0;
        bus.i_req_wen   = 1'b0;
        bus.i_req_addr  = '0;
        bus.i_req_wdata = '0;
        bus.i_req_wmask = '0;
        bus.i_rsp_ready = 1'b0;
        test_reset();
        test_store_load();
        test_byte_store();
        test_errors();
        test_backpressure();
        test_reset_abort();
`ifdef DMEM_RAND_DELAY_EN
        test_rand_delay();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dmem_resp.md
DMEM_RESP -- requirements
Module: dmem_resp

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h8000_0000, meaning byte address of word 0.
REQ-002 SHALL have parameter DEPTH_WORDS, default 1024, meaning number of 32-bit storage words (power of two).
REQ-003 SHALL have parameter LATENCY, default 2, meaning fixed cycles from request accept to response valid (range 1..15).
REQ-004 SHALL have ports: i_clk input 1 clock; i_rst input 1 reset (one clock; reset is asynchronous and active-high).
REQ-005 SHALL have ports: i_req_valid input 1 request valid; o_req_ready output 1 request ready; i_req_wen input 1 1=store, 0=load.
REQ-006 SHALL have ports: i_req_addr input 32 byte address; i_req_wdata input 32 store data, LSB-aligned; i_req_wmask input 8 byte mask, LSB-aligned, bits 7:4 ignored.
REQ-007 SHALL have ports: o_rsp_valid output 1 response valid; i_rsp_ready input 1 response ready; o_rsp_rdata output 32 load data, LSB-aligned; o_rsp_err output 1 access error.

Function
REQ-008 SHALL implement FSM states IDLE, WAIT, RESP; o_req_ready=1 only in IDLE.
REQ-009 SHALL accept a request on a cycle with i_req_valid&&o_req_ready, capturing wen/addr/wdata/wmask, and go IDLE->WAIT.
REQ-010 SHALL load a down-counter with LATENCY-1 on accept, decrement each WAIT cycle, and go WAIT->RESP when it reaches 0, so o_rsp_valid rises exactly LATENCY cycles after accept.
REQ-011 SHALL hold o_rsp_valid, o_rsp_rdata, o_rsp_err stable in RESP until i_rsp_ready=1, then go RESP->IDLE; o_req_ready re-asserts the cycle after the response handshake (no back-to-back accept).
REQ-012 SHALL compute offset=addr[1:0], index=(addr-BASE_ADDR)>>2; lane mask = wmask[3:0]<<offset.
REQ-013 SHALL flag err when addr<BASE_ADDR, index>=DEPTH_WORDS, or (wmask[3:0]<<offset) has any bit above bit 3.
REQ-014 SHALL, for a store without err, write byte lane k of word[index] with wdata<<(8*offset) when lane mask bit k=1, exactly once, at the WAIT->RESP transition; o_rsp_rdata=0.
REQ-015 SHALL, for a load without err, return word[index]>>(8*offset) with zero fill in upper bytes, sampled at WAIT->RESP.
REQ-016 SHALL, on err, suppress any write and drive o_rsp_rdata=0, o_rsp_err=1.
REQ-017 SHALL treat a store with wmask[3:0]=0 as a legal no-op completing with err=0.
REQ-018 SHALL ignore i_rsp_ready outside RESP and i_req_* outside IDLE.

Reset
REQ-019 SHALL on i_rst=1 asynchronously force state IDLE, counter 0, o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0; o_req_ready=1 after release.
REQ-020 SHALL abort any in-flight request on reset mid-operation; a store not yet committed (REQ-014) SHALL NOT be written.
REQ-021 SHALL NOT reset storage contents.

Configuration
REQ-022 SHALL, with DMEM_RAND_DELAY_EN defined, add 0..3 extra WAIT cycles per request taken from bits [1:0] of a 16-bit LFSR (seed 16'hACE1 on reset, steps once per accept).
REQ-023 SHALL, without DMEM_RAND_DELAY_EN, use exactly LATENCY cycles and contain no LFSR logic.

Structure
REQ-024 SHALL place the FSM state enum (IDLE/WAIT/RESP), CPU width constant 32, and LFSR seed in shared package dmem_pkg.
REQ-025 SHALL instantiate one sub-module dmem_lfsr (16-bit Galois LFSR, enable input) only under DMEM_RAND_DELAY_EN.

Verification
REQ-026 Store addr 0x8000_0000 wdata 0xDEADBEEF wmask 0x0F, then load same -> rdata 0xDEADBEEF, err 0, valid exactly 2 cycles after each accept.
REQ-027 Store byte addr 0x8000_0006 wdata 0x000000A5 wmask 0x01 over word 0x11223344, load 0x8000_0004 -> 0x11A53344.
REQ-028 Load addr 0x8000_0003 wmask-irrelevant halfword store wmask 0x03 at 0x8000_0003 -> err 1, memory unchanged; load 0x7FFF_FFFC -> err 1, rdata 0.
REQ-029 Hold i_rsp_ready=0 for 5 cycles in RESP -> valid/rdata/err stable, o_req_ready=0, second request not accepted until cycle after handshake.
REQ-030 Assert i_rst one cycle after store accept to 0x8000_0010 (old 0x0) -> o_rsp_valid=0 immediately, later load returns 0x0.
REQ-031 With DMEM_RAND_DELAY_EN, 100 loads -> every latency in 2..5, data correct.
